// File: rtl/teclado_digitos_pkg.sv
// Shared types for the keypad password path: packet type, key codes, sentinel packets
// and FSM state encoding.
package teclado_digitos_pkg;

    localparam int SENHA_DIGITS = 20;

    // digit[0] is the most recent key; unused digits hold 4'hF
    typedef logic [SENHA_DIGITS-1:0][3:0] senhaPac_t;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    localparam senhaPac_t SENHA_VAZIA   = {SENHA_DIGITS{4'hF}};
    localparam senhaPac_t SENHA_SAIR    = {SENHA_DIGITS{4'hB}};
    localparam senhaPac_t SENHA_TIMEOUT = {SENHA_DIGITS{4'hE}};

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ENTRY    = 2'd1,
        ST_SEND     = 2'd2
    } estado_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'h9;
    endfunction

endpackage

// File: rtl/teclado_digitos_tick_ms.sv
// Free-running 1 ms tick divisor; one-cycle pulse every CLK_HZ/1000 clocks, restarted by i_clear.
module tick_ms #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int DIV   = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A clear cycle never emits a tick, so the window restarts cleanly after a key.
    assign o_tick = w_wrap && !i_clear;

endmodule

// File: rtl/teclado_digitos.sv
// Keypad digit accumulator: builds a 20-digit BCD packet and strobes it out on '#', '*' or timeout.
// Optional build macro TECLADO_BACKSPACE_EN turns '*' on a non-empty buffer into a backspace.
module teclado_digitos
    import teclado_digitos_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TIMEOUT_MS = 5000,
    parameter int MAX_DIGITS = SENHA_DIGITS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output senhaPac_t  digitos_value,
    output logic       digitos_valid
);

    localparam int TIMER_W = $clog2(TIMEOUT_MS + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_MS - 1);

    estado_t            r_state;
    estado_t            w_state_next;
    senhaPac_t          r_buffer;
    senhaPac_t          w_buffer_next;
    senhaPac_t          w_send_value;
    senhaPac_t          w_push;
    logic               r_valid;
    logic               w_valid_next;
    logic [TIMER_W-1:0] r_timer;
    logic               w_tick;
    logic               w_timer_clr;
    logic               w_empty;
    logic               w_key_accept;
    logic               w_expire;

    // Digits are never 0xF, so the newest slot alone tells whether anything was typed.
    assign w_empty      = (r_buffer[0] == 4'hF);
    assign w_key_accept = (r_state == ST_ENTRY) && enable && key_valid && (key_code <= KEY_HASH);
    assign w_push       = {r_buffer[MAX_DIGITS-2:0], key_code};

`ifdef TECLADO_BACKSPACE_EN
    senhaPac_t w_pop;
    assign w_pop = {4'hF, r_buffer[MAX_DIGITS-1:1]};
`endif

    // Timer only runs in ENTRY with something typed; any accepted key restarts the window.
    assign w_timer_clr = (r_state != ST_ENTRY) || w_key_accept || w_empty;
    assign w_expire    = w_tick && (r_timer == TIMER_LAST);

    tick_ms #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_ms (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_timer_clr),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if (w_timer_clr) begin
            r_timer <= '0;
        end else if (w_tick) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_DISABLED;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_send_value = SENHA_VAZIA;
        case (r_state)
            ST_DISABLED: begin
                if (enable) begin
                    w_state_next = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (!enable) begin
                    w_state_next = ST_DISABLED;
                end else if (w_key_accept) begin
                    if (key_code == KEY_HASH) begin
                        w_state_next = ST_SEND;
                        w_send_value = r_buffer;
                    end else if (key_code == KEY_STAR) begin
`ifdef TECLADO_BACKSPACE_EN
                        if (w_empty) begin
                            w_state_next = ST_SEND;
                            w_send_value = SENHA_SAIR;
                        end
`else
                        w_state_next = ST_SEND;
                        w_send_value = SENHA_SAIR;
`endif
                    end
                end else if (w_expire) begin
                    w_state_next = ST_SEND;
                    w_send_value = SENHA_TIMEOUT;
                end
            end
            ST_SEND: begin
                w_state_next = enable ? ST_ENTRY : ST_DISABLED;
            end
            default: begin
                w_state_next = ST_DISABLED;
            end
        endcase
    end

    // The buffer doubles as the output register: it holds the result during SEND.
    always_comb begin
        w_buffer_next = SENHA_VAZIA;
        w_valid_next  = 1'b0;
        if (w_state_next == ST_SEND) begin
            w_buffer_next = w_send_value;
            w_valid_next  = 1'b1;
        end else if ((r_state == ST_ENTRY) && (w_state_next == ST_ENTRY)) begin
            w_buffer_next = r_buffer;
            if (w_key_accept && is_digit(key_code)) begin
                w_buffer_next = w_push;
            end
`ifdef TECLADO_BACKSPACE_EN
            else if (w_key_accept && (key_code == KEY_STAR)) begin
                w_buffer_next = w_pop;
            end
`endif
        end
    end

    // NOTE: the packet is a bank of ordinary flops, not a RAM, so it takes the reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buffer <= SENHA_VAZIA;
            r_valid  <= 1'b0;
        end else begin
            r_buffer <= w_buffer_next;
            r_valid  <= w_valid_next;
        end
    end

    assign digitos_value = r_buffer;
    assign digitos_valid = r_valid;

endmodule
